road_speed_ctrl: RTL and testbench
==================================

ROAD_SPEED_CTRL -- requirements
Module: road_speed_ctrl

Interface
REQ-001 Parameter SPEED_W, 4, width of road_speed.
REQ-002 Parameter MAX_SPEED, 5, speed ceiling with gas and no turbo.
REQ-003 Parameter TURBO_MAX_SPEED, 10, speed ceiling while turbo is active; legal only if MAX_SPEED <= TURBO_MAX_SPEED <= 2^SPEED_W-1.
REQ-004 Parameter ACCEL_STEP / BRAKE_STEP / COAST_STEP, 1 / 2 / 1, per-frame speed deltas.
REQ-005 Parameter CRASH_FRAMES, 30, frames frozen after a collision (>=1).
REQ-006 Parameter TURBO_FRAMES / TURBO_COOLDOWN, 90 / 60, turbo duration and re-arm delay in frames (>=1).
REQ-007 Parameter DIST_W, 16, odometer width.
REQ-008 One clock; reset is synchronous and active-high.
REQ-009 clk  in  1  system clock.
REQ-010 reset  in  1  synchronous active-high reset.
REQ-011 startOfFrame  in  1  one-cycle pulse per frame; all state updates occur only on clk edges where it is 1.
REQ-012 gas_button / brake_button  in  1 each  accelerate / decelerate requests.
REQ-013 turbo_req  in  1  turbo request, sampled at startOfFrame.
REQ-014 road_collision  in  1  collision indication, sampled at startOfFrame.
REQ-015 odo_clear  in  1  clears odometer.
REQ-016 road_speed  out  SPEED_W  current registered speed.
REQ-017 crashed  out  1  high while in CRASH state.
REQ-018 turbo_active  out  1  high while turbo is ON.
REQ-019 turbo_ready  out  1  high while turbo may be armed.
REQ-020 distance  out  DIST_W  saturating sum of road_speed per frame.

Function
REQ-021 Main FSM SHALL have states IDLE, DRIVE, CRASH; IDLE->DRIVE on first startOfFrame, no speed change that frame.
REQ-022 In DRIVE at startOfFrame, priority order: road_collision -> speed 0, enter CRASH, load crash counter CRASH_FRAMES; gas&brake -> hold; gas -> approach limit; brake -> speed-BRAKE_STEP floored at 0; neither -> speed-COAST_STEP floored at 0.
REQ-023 Gas limit SHALL be TURBO_MAX_SPEED if turbo_active else MAX_SPEED; below limit: speed+ACCEL_STEP clamped to limit; above limit: speed-COAST_STEP clamped to limit; equal: hold.
REQ-024 Arithmetic SHALL be computed at width SPEED_W+1 or wider; no wrap-around at either bound.
REQ-025 In CRASH: speed held 0, gas/brake/turbo_req ignored, counter decrements per startOfFrame; when it decrements to 0 -> DRIVE, so crashed is high for exactly CRASH_FRAMES frames.
REQ-026 road_collision in CRASH SHALL reload counter to CRASH_FRAMES.
REQ-027 Turbo FSM states READY, ON, COOL; READY->ON when turbo_req=1 at startOfFrame in DRIVE without collision, loading TURBO_FRAMES; ON counts down, at 0 ->COOL loading TURBO_COOLDOWN; COOL counts down, at 0 ->READY.
REQ-028 turbo_req in ON or COOL SHALL be ignored; entering CRASH SHALL force turbo ON->COOL with TURBO_COOLDOWN loaded.
REQ-029 Turbo arming frame: speed update in that same frame already uses TURBO_MAX_SPEED limit.
REQ-030 Turbo ending: excess speed decays by COAST_STEP per frame toward MAX_SPEED under gas.
REQ-031 distance SHALL add pre-update road_speed each startOfFrame in DRIVE/CRASH, saturating at 2^DIST_W-1.
REQ-032 odo_clear SHALL zero distance on that cycle, overriding any same-cycle add.
REQ-033 All outputs registered; new values visible the cycle after the startOfFrame edge.

Reset
REQ-034 reset SHALL, on the next clk edge, set main FSM IDLE, turbo FSM READY, all counters 0, road_speed 0, crashed 0, turbo_active 0, turbo_ready 1, distance 0.
REQ-035 reset SHALL take priority over all inputs, including mid-CRASH and mid-turbo.

Verification
REQ-036 Reset, 1 SOF, gas held 7 SOFs -> road_speed 1,2,3,4,5,5,5.
REQ-037 At speed 5, gas + turbo_req one SOF -> speed 6..10 over 5 SOFs, holds 10; turbo_active drops after 90 SOFs; speed 9,8,7,6,5; turbo_ready returns 60 SOFs later.
REQ-038 At speed 5, brake only -> 3,1,0,0; gas+brake at 3 -> holds 3.
REQ-039 At speed 7 with turbo ON, road_collision one SOF -> speed 0, crashed=1, turbo_active=0 next cycle; gas held, speed stays 0 for 30 SOFs, then 1.
REQ-040 Odometer: speeds 1,2,3 -> distance 0,1,3,6; preset near 65535 -> saturates at 65535; odo_clear with SOF -> 0.
REQ-041 reset asserted mid-CRASH -> all outputs reset values next cycle; FSM leaves IDLE on next SOF.

Source files
------------

// File: rtl/road_speed_ctrl.sv
// Frame-paced road speed controller: gas/brake/coast speed model with crash freeze,
// a turbo boost that has a cooldown, and a saturating odometer.
module road_speed_ctrl #(
    parameter int SPEED_W         = 4,
    parameter int MAX_SPEED       = 5,
    parameter int TURBO_MAX_SPEED = 10,
    parameter int ACCEL_STEP      = 1,
    parameter int BRAKE_STEP      = 2,
    parameter int COAST_STEP      = 1,
    parameter int CRASH_FRAMES    = 30,
    parameter int TURBO_FRAMES    = 90,
    parameter int TURBO_COOLDOWN  = 60,
    parameter int DIST_W          = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               gas_button,
    input  logic               brake_button,
    input  logic               turbo_req,
    input  logic               road_collision,
    input  logic               odo_clear,
    output logic [SPEED_W-1:0] road_speed,
    output logic               crashed,
    output logic               turbo_active,
    output logic               turbo_ready,
    output logic [DIST_W-1:0]  distance
);
    // Two spare bits so speed +/- step never wraps before clamping.
    localparam int AW   = SPEED_W + 2;
    localparam int DW1  = DIST_W + 1;
    localparam int CW   = $clog2(CRASH_FRAMES + 1);
    localparam int TMAX = (TURBO_FRAMES > TURBO_COOLDOWN) ? TURBO_FRAMES : TURBO_COOLDOWN;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [AW-1:0] MAX_LIM   = AW'(MAX_SPEED);
    localparam logic [AW-1:0] TURBO_LIM = AW'(TURBO_MAX_SPEED);
    localparam logic [AW-1:0] ACC       = AW'(ACCEL_STEP);
    localparam logic [AW-1:0] BRK       = AW'(BRAKE_STEP);
    localparam logic [AW-1:0] CST       = AW'(COAST_STEP);

    typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, CRASH = 2'd2} main_t;
    typedef enum logic [1:0] {T_READY = 2'd0, T_ON = 2'd1, T_COOL = 2'd2} turbo_t;

    main_t              main_r, main_n;
    turbo_t             turbo_r, turbo_n;
    logic [CW-1:0]      crash_cnt_r, crash_cnt_n;
    logic [TW-1:0]      turbo_cnt_r, turbo_cnt_n;
    logic [SPEED_W-1:0] speed_n;
    logic [DIST_W-1:0]  dist_n;
    logic               arm_s, boost_s;
    logic [AW-1:0]      cur_s, limit_s, drive_spd_s;
    logic [DW1-1:0]     dist_sum_s;

    // Turbo arming applies its raised limit in the very frame it is armed.
    assign arm_s   = (turbo_r == T_READY) && turbo_req && (main_r == DRIVE) && !road_collision;
    assign boost_s = (turbo_r == T_ON) || arm_s;

    // Candidate DRIVE-state speed for this frame from the pedal inputs.
    always_comb begin
        cur_s       = AW'(road_speed);
        limit_s     = boost_s ? TURBO_LIM : MAX_LIM;
        drive_spd_s = cur_s;
        if (gas_button && brake_button) begin
            drive_spd_s = cur_s;
        end else if (gas_button) begin
            if (cur_s < limit_s) begin
                drive_spd_s = ((cur_s + ACC) > limit_s) ? limit_s : (cur_s + ACC);
            end else if (cur_s > limit_s) begin
                drive_spd_s = (cur_s >= (limit_s + CST)) ? (cur_s - CST) : limit_s;
            end else begin
                drive_spd_s = cur_s;
            end
        end else if (brake_button) begin
            drive_spd_s = (cur_s > BRK) ? (cur_s - BRK) : {AW{1'b0}};
        end else begin
            drive_spd_s = (cur_s > CST) ? (cur_s - CST) : {AW{1'b0}};
        end
    end

    // Main FSM, crash counter, speed and odometer next-state.
    always_comb begin
        main_n      = main_r;
        crash_cnt_n = crash_cnt_r;
        speed_n     = road_speed;
        dist_n      = distance;
        dist_sum_s  = {1'b0, distance} + DW1'(road_speed);
        if (startOfFrame) begin
            case (main_r)
                IDLE: main_n = DRIVE;
                DRIVE: begin
                    if (road_collision) begin
                        main_n      = CRASH;
                        speed_n     = {SPEED_W{1'b0}};
                        crash_cnt_n = CW'(CRASH_FRAMES);
                    end else begin
                        speed_n = drive_spd_s[SPEED_W-1:0];
                    end
                end
                CRASH: begin
                    speed_n = {SPEED_W{1'b0}};
                    if (road_collision) begin
                        crash_cnt_n = CW'(CRASH_FRAMES);
                    end else if (crash_cnt_r <= CW'(1)) begin
                        crash_cnt_n = {CW{1'b0}};
                        main_n      = DRIVE;
                    end else begin
                        crash_cnt_n = crash_cnt_r - CW'(1);
                    end
                end
                default: main_n = IDLE;
            endcase
            if (main_r != IDLE) begin
                dist_n = dist_sum_s[DIST_W] ? {DIST_W{1'b1}} : dist_sum_s[DIST_W-1:0];
            end else begin
                dist_n = distance;
            end
        end else begin
            main_n = main_r;
        end
        if (odo_clear) begin
            dist_n = {DIST_W{1'b0}};
        end else begin
            dist_n = dist_n;
        end
    end

    // Turbo FSM next-state; a crash cuts an active turbo straight into cooldown.
    always_comb begin
        turbo_n     = turbo_r;
        turbo_cnt_n = turbo_cnt_r;
        if (startOfFrame) begin
            case (turbo_r)
                T_READY: begin
                    if (arm_s) begin
                        turbo_n     = T_ON;
                        turbo_cnt_n = TW'(TURBO_FRAMES);
                    end else begin
                        turbo_n = T_READY;
                    end
                end
                T_ON: begin
                    if (((main_r == DRIVE) && road_collision) || (turbo_cnt_r <= TW'(1))) begin
                        turbo_n     = T_COOL;
                        turbo_cnt_n = TW'(TURBO_COOLDOWN);
                    end else begin
                        turbo_cnt_n = turbo_cnt_r - TW'(1);
                    end
                end
                T_COOL: begin
                    if (turbo_cnt_r <= TW'(1)) begin
                        turbo_n     = T_READY;
                        turbo_cnt_n = {TW{1'b0}};
                    end else begin
                        turbo_cnt_n = turbo_cnt_r - TW'(1);
                    end
                end
                default: turbo_n = T_READY;
            endcase
        end else begin
            turbo_n = turbo_r;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_r       <= IDLE;
            turbo_r      <= T_READY;
            crash_cnt_r  <= {CW{1'b0}};
            turbo_cnt_r  <= {TW{1'b0}};
            road_speed   <= {SPEED_W{1'b0}};
            crashed      <= 1'b0;
            turbo_active <= 1'b0;
            turbo_ready  <= 1'b1;
            distance     <= {DIST_W{1'b0}};
        end else begin
            main_r       <= main_n;
            turbo_r      <= turbo_n;
            crash_cnt_r  <= crash_cnt_n;
            turbo_cnt_r  <= turbo_cnt_n;
            road_speed   <= speed_n;
            crashed      <= (main_n == CRASH);
            turbo_active <= (turbo_n == T_ON);
            turbo_ready  <= (turbo_n == T_READY);
            distance     <= dist_n;
        end
    end
endmodule

// File: tb/tb_road_speed_ctrl.sv
// Bench for road_speed_ctrl: frame-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_road_speed_ctrl;
    localparam int MAXS = 5, TMAXS = 10, CRASH_N = 30, TURBO_N = 90, COOL_N = 60, DSAT = 65535;

    logic clk = 1'b0;
    logic reset = 1'b1, sof = 1'b0, gas = 1'b0, brake = 1'b0, treq = 1'b0, coll = 1'b0, clr = 1'b0;
    logic [3:0]  road_speed;
    logic        crashed, turbo_active, turbo_ready;
    logic [15:0] distance;

    int n_checks = 0, n_errors = 0;
    bit chk_en = 1'b0;

    // Model: mode 0 idle / 1 driving / 2 crashed; turbo 0 ready / 1 on / 2 cooling.
    int m_mode = 0, m_crash_left = 0, m_turbo = 0, m_turbo_left = 0, m_speed = 0, m_dist = 0;

    road_speed_ctrl dut (
        .clk(clk), .reset(reset), .startOfFrame(sof), .gas_button(gas), .brake_button(brake),
        .turbo_req(treq), .road_collision(coll), .odo_clear(clr), .road_speed(road_speed),
        .crashed(crashed), .turbo_active(turbo_active), .turbo_ready(turbo_ready), .distance(distance)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model advanced on each clock edge from the sampled inputs.
    always @(posedge clk) begin
        int mode, cl, tb, tl, spd, dst, lim;
        bit boost;
        mode = m_mode; cl = m_crash_left; tb = m_turbo; tl = m_turbo_left; spd = m_speed; dst = m_dist;
        if (reset) begin
            mode = 0; cl = 0; tb = 0; tl = 0; spd = 0; dst = 0;
        end else begin
            if (sof) begin
                boost = (m_turbo == 1) || (m_turbo == 0 && treq && m_mode == 1 && !coll);
                if (m_mode != 0) dst = (m_dist + m_speed > DSAT) ? DSAT : m_dist + m_speed;
                if (m_mode == 0) mode = 1;
                else if (m_mode == 1) begin
                    if (coll) begin mode = 2; spd = 0; cl = CRASH_N; end
                    else if (gas && brake) spd = m_speed;
                    else if (gas) begin
                        lim = boost ? TMAXS : MAXS;
                        if (m_speed < lim) spd = (m_speed + 1 > lim) ? lim : m_speed + 1;
                        else if (m_speed > lim) spd = (m_speed - 1 < lim) ? lim : m_speed - 1;
                    end
                    else if (brake) spd = (m_speed < 2) ? 0 : m_speed - 2;
                    else spd = (m_speed < 1) ? 0 : m_speed - 1;
                end else begin
                    spd = 0;
                    if (coll) cl = CRASH_N;
                    else begin cl = m_crash_left - 1; if (cl == 0) mode = 1; end
                end
                if (m_turbo == 1 && m_mode == 1 && coll) begin tb = 2; tl = COOL_N; end
                else if (m_turbo == 0) begin
                    if (boost) begin tb = 1; tl = TURBO_N; end
                end else begin
                    tl = m_turbo_left - 1;
                    if (tl == 0) begin
                        if (m_turbo == 1) begin tb = 2; tl = COOL_N; end
                        else tb = 0;
                    end
                end
            end
            if (clr) dst = 0;
        end
        m_mode <= mode; m_crash_left <= cl; m_turbo <= tb; m_turbo_left <= tl; m_speed <= spd; m_dist <= dst;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_speed", road_speed, m_speed);
            chk("model_crashed", crashed, (m_mode == 2) ? 1 : 0);
            chk("model_turbo_active", turbo_active, (m_turbo == 1) ? 1 : 0);
            chk("model_turbo_ready", turbo_ready, (m_turbo == 0) ? 1 : 0);
            chk("model_distance", distance, m_dist);
        end
    end

    task automatic frame(input bit g, input bit b, input bit t, input bit c, input bit o);
        sof = 1'b1; gas = g; brake = b; treq = t; coll = c; clr = o;
        @(posedge clk); #1;
        sof = 1'b0; gas = 1'b0; brake = 1'b0; treq = 1'b0; coll = 1'b0; clr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic gas_frames(input int n);
        for (int i = 0; i < n; i++) frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int spd_seq[7]  = '{1, 2, 3, 4, 5, 5, 5};
        int dist_seq[7] = '{0, 1, 3, 6, 10, 15, 20};
        int brk_seq[4]  = '{3, 1, 0, 0};
        @(posedge clk); #1;
        chk_en = 1'b1;
        do_reset();
        chk("rst_speed", road_speed, 0);
        chk("rst_ready", turbo_ready, 1);
        chk("rst_distance", distance, 0);
        chk("rst_crashed", crashed, 0);

        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_exit_speed", road_speed, 0);
        for (int i = 0; i < 7; i++) begin
            frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("accel_speed", road_speed, spd_seq[i]);
            chk("accel_distance", distance, dist_seq[i]);
        end

        frame(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("turbo_arm_speed", road_speed, 6);
        chk("turbo_arm_active", turbo_active, 1);
        gas_frames(4);
        chk("turbo_top_speed", road_speed, 10);
        gas_frames(85);
        chk("turbo_still_on", turbo_active, 1);
        gas_frames(1);
        chk("turbo_end_active", turbo_active, 0);
        chk("turbo_end_speed", road_speed, 10);
        for (int i = 0; i < 5; i++) begin
            gas_frames(1);
            chk("turbo_decay_speed", road_speed, 9 - i);
        end
        gas_frames(54);
        chk("cool_not_ready", turbo_ready, 0);
        gas_frames(1);
        chk("cool_ready", turbo_ready, 1);

        for (int i = 0; i < 4; i++) begin
            frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("brake_speed", road_speed, brk_seq[i]);
        end
        gas_frames(3);
        frame(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("gas_brake_hold", road_speed, 3);

        frame(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        gas_frames(3);
        chk("pre_crash_speed", road_speed, 7);
        frame(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("crash_speed", road_speed, 0);
        chk("crash_flag", crashed, 1);
        chk("crash_turbo_off", turbo_active, 0);
        gas_frames(29);
        chk("crash_hold_flag", crashed, 1);
        chk("crash_hold_speed", road_speed, 0);
        gas_frames(1);
        chk("crash_exit_flag", crashed, 0);
        gas_frames(1);
        chk("crash_exit_speed", road_speed, 1);

        for (int i = 0; i < 20000 && m_dist < DSAT; i++) frame(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        gas_frames(3);
        chk("odo_saturate", distance, DSAT);
        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("odo_clear_sof", distance, 0);

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            sof   = $urandom_range(0, 1);
            gas   = ($urandom_range(0, 9) < 7);
            brake = ($urandom_range(0, 9) < 3);
            treq  = ($urandom_range(0, 4) == 0);
            coll  = ($urandom_range(0, 29) == 0);
            clr   = ($urandom_range(0, 99) == 0);
            @(posedge clk); #1;
        end
        reset = 1'b0; sof = 1'b0; gas = 1'b0; brake = 1'b0; treq = 1'b0; coll = 1'b0; clr = 1'b0;

        do_reset();
        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        gas_frames(3);
        frame(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        gas_frames(5);
        chk("midcrash_flag", crashed, 1);
        do_reset();
        chk("midcrash_rst_speed", road_speed, 0);
        chk("midcrash_rst_crashed", crashed, 0);
        chk("midcrash_rst_active", turbo_active, 0);
        chk("midcrash_rst_ready", turbo_ready, 1);
        chk("midcrash_rst_distance", distance, 0);
        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_idle_exit", road_speed, 0);
        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_drive", road_speed, 1);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
